// File: rtl/gsim_xcollect.sv
// Double-banked collector for solver result vectors: converts Q16.16 words to
// saturated Q8.8 at capture and replays each completed vector over a ready/valid port.
module gsim_xcollect #(
    parameter int N          = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   x_valid,
    input  logic [31:0]            x_in,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [15:0]            o_data,
    output logic [$clog2(N)-1:0]   o_idx,
    output logic                   o_last,
    output logic                   err_ovf
);

    localparam int IW = $clog2(N);
    localparam logic signed [32:0] ROUND = 33'sd1 <<< (FRAC_SHIFT - 1);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    bank_state_t       bank_state [2];
    logic [15:0]       mem [2][N];
    logic              wr_bank;
    logic [IW-1:0]     wr_cnt;
    logic              rd_bank;
    logic [IW-1:0]     rd_cnt;
    logic              drop_mode;

    logic signed [32:0] x_ext;
    logic signed [32:0] x_round;
    logic signed [32:0] x_shift;
    logic [15:0]        x_conv;

    logic rd_fire;
    logic rd_free;
    logic wr_target_empty;
    logic drop_now;

    assign x_ext   = {x_in[31], x_in};
    assign x_round = x_ext + ROUND;
    assign x_shift = x_round >>> FRAC_SHIFT;

    always_comb begin
        x_conv = x_shift[15:0];
        if (x_shift > 33'sd32767)
            x_conv = 16'h7FFF;
        else if (x_shift < -33'sd32768)
            x_conv = 16'h8000;
    end

    assign o_valid = (bank_state[rd_bank] == FULL) || (bank_state[rd_bank] == DRAINING);
    assign o_data  = o_valid ? mem[rd_bank][rd_cnt] : 16'h0000;
    assign o_idx   = rd_cnt;
    assign o_last  = (rd_cnt == IW'(N - 1));

    assign rd_fire = o_valid && o_ready;
    assign rd_free = rd_fire && (rd_cnt == IW'(N - 1));

    // A bank released by this cycle's final read counts as free for a vector starting now.
    assign wr_target_empty = (bank_state[wr_bank] == EMPTY) || (rd_free && (rd_bank == wr_bank));
    assign drop_now        = (wr_cnt == '0) ? !wr_target_empty : drop_mode;

    // Write-side status updates follow the read-side ones so a refill of a just-freed bank wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            wr_bank       <= 1'b0;
            wr_cnt        <= '0;
            rd_bank       <= 1'b0;
            rd_cnt        <= '0;
            drop_mode     <= 1'b0;
            err_ovf       <= 1'b0;
        end else begin
            if (rd_fire) begin
                if (rd_cnt == IW'(N - 1)) begin
                    bank_state[rd_bank] <= EMPTY;
                    rd_cnt              <= '0;
                    rd_bank             <= ~rd_bank;
                end else begin
                    bank_state[rd_bank] <= DRAINING;
                    rd_cnt              <= rd_cnt + 1'b1;
                end
            end

            if (x_valid) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == '0)
                    drop_mode <= drop_now;
                if (drop_now) begin
                    err_ovf <= 1'b1;
                end else if (wr_cnt == '0) begin
                    bank_state[wr_bank] <= FILLING;
                end else if (wr_cnt == IW'(N - 1)) begin
                    bank_state[wr_bank] <= FULL;
                    wr_bank             <= ~wr_bank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && x_valid && !drop_now)
            mem[wr_bank][wr_cnt] <= x_conv;
    end

endmodule

// File: tb/tb_gsim_xcollect.sv
// Directed bench for gsim_xcollect: conversion, ordering, overflow drop,
// stall stability and mid-vector reset, each checked with immediate assertions.
module tb_gsim_xcollect;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        x_valid;
    logic [31:0] x_in;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_data;
    logic [3:0]  o_idx;
    logic        o_last;
    logic        err_ovf;

    int          compared   = 0;
    int          mismatched = 0;
    int          delivered  = 0;
    int          exp_idx    = 0;
    logic [15:0] exp_q [$];
    bit          held = 1'b0;
    logic [15:0] held_data;
    logic [3:0]  held_idx;
    logic        held_last;
    bit          rdy_t = 1'b0;

    gsim_xcollect #(.N(N), .FRAC_SHIFT(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .x_valid (x_valid),
        .x_in    (x_in),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_idx   (o_idx),
        .o_last  (o_last),
        .err_ovf (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Vector v, word k converts to {v,k} as a Q8.8 word, so order is visible in the data.
    function automatic logic [31:0] patWord(input int v, input int k);
        return {8'h00, v[7:0], k[7:0], 8'h00};
    endfunction

    task automatic applyStimulus(input logic xv, input logic [31:0] xd, input logic rdy);
        x_valid = xv;
        x_in    = xd;
        o_ready = rdy;
        if (held) begin
            checkOutput("stall_valid", {31'd0, o_valid}, 32'd1);
            checkOutput("stall_data", {16'd0, o_data}, {16'd0, held_data});
            checkOutput("stall_idx", {28'd0, o_idx}, {28'd0, held_idx});
            checkOutput("stall_last", {31'd0, o_last}, {31'd0, held_last});
        end
        held = 1'b0;
        if (o_valid && rdy && exp_q.size() > 0) begin
            checkOutput("data", {16'd0, o_data}, {16'd0, exp_q.pop_front()});
            checkOutput("idx", {28'd0, o_idx}, exp_idx);
            checkOutput("last", {31'd0, o_last}, {31'd0, (exp_idx == N - 1)});
            exp_idx = (exp_idx + 1) % N;
            delivered++;
        end else if (o_valid && !rdy) begin
            held      = 1'b1;
            held_data = o_data;
            held_idx  = o_idx;
            held_last = o_last;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset   = 1'b1;
        x_valid = 1'b0;
        x_in    = '0;
        o_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_idx   = 0;
        held      = 1'b0;
        delivered = 0;
    endtask

    task automatic sendVector(input int v, input logic rdy, input bit expect_it);
        for (int k = 0; k < N; k++) begin
            if (expect_it)
                exp_q.push_back({v[7:0], k[7:0]});
            applyStimulus(1'b1, patWord(v, k), rdy);
        end
    endtask

    task automatic drainAll(input int budget, input bit toggle);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
            applyStimulus(1'b0, 32'd0, toggle ? rdy_t : 1'b1);
            rdy_t = ~rdy_t;
        end
        checkOutput("drain_empty", exp_q.size(), 32'd0);
        checkOutput("idle_valid", {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        x_valid = 1'b0;
        x_in    = '0;
        o_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("rst_data", {16'd0, o_data}, 32'd0);
        checkOutput("rst_idx", {28'd0, o_idx}, 32'd0);
        checkOutput("rst_last", {31'd0, o_last}, 32'd0);
        checkOutput("rst_ovf", {31'd0, err_ovf}, 32'd0);

        $display("[TB] constant vector, latency and index sequence");
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(16'h0180);
            checkOutput("lat_pre_valid", {31'd0, o_valid}, 32'd0);
            applyStimulus(1'b1, 32'h0001_8000, 1'b1);
        end
        checkOutput("lat_valid", {31'd0, o_valid}, 32'd1);
        drainAll(20, 1'b0);
        checkOutput("v1_count", delivered, 32'd16);

        $display("[TB] rounding and saturation");
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h7FFF);
        exp_q.push_back(16'h8000);
        applyStimulus(1'b1, 32'h0000_0080, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FF80, 1'b1);
        applyStimulus(1'b1, 32'h7FFF_0000, 1'b1);
        applyStimulus(1'b1, 32'h8000_0000, 1'b1);
        for (int k = 4; k < N; k++) begin
            exp_q.push_back(16'h0000);
            applyStimulus(1'b1, 32'h0000_0000, 1'b1);
        end
        drainAll(20, 1'b0);

        $display("[TB] overflow: third vector dropped while stalled");
        delivered = 0;
        sendVector(1, 1'b0, 1'b1);
        sendVector(2, 1'b0, 1'b1);
        checkOutput("ovf_before", {31'd0, err_ovf}, 32'd0);
        checkOutput("ovf_held_valid", {31'd0, o_valid}, 32'd1);
        applyStimulus(1'b1, patWord(3, 0), 1'b0);
        checkOutput("ovf_first", {31'd0, err_ovf}, 32'd1);
        for (int k = 1; k < N; k++)
            applyStimulus(1'b1, patWord(3, k), 1'b0);
        drainAll(40, 1'b0);
        checkOutput("ovf_count", delivered, 32'd32);
        sendVector(4, 1'b1, 1'b1);
        drainAll(20, 1'b0);
        checkOutput("ovf_sticky", {31'd0, err_ovf}, 32'd1);

        $display("[TB] streaming with toggling ready");
        doReset();
        checkOutput("stream_ovf_clr", {31'd0, err_ovf}, 32'd0);
        rdy_t = 1'b1;
        for (int v = 5; v <= 7; v++) begin
            for (int k = 0; k < N; k++) begin
                exp_q.push_back({v[7:0], k[7:0]});
                applyStimulus(1'b1, patWord(v, k), rdy_t);
                rdy_t = ~rdy_t;
                repeat (2) begin
                    applyStimulus(1'b0, 32'd0, rdy_t);
                    rdy_t = ~rdy_t;
                end
            end
        end
        drainAll(80, 1'b1);
        checkOutput("stream_count", delivered, 32'd48);
        checkOutput("stream_ovf", {31'd0, err_ovf}, 32'd0);

        $display("[TB] reset mid-vector");
        sendVector(9, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b1, patWord(10, k), 1'b0);
        checkOutput("mid_pre_valid", {31'd0, o_valid}, 32'd1);
        doReset();
        checkOutput("mid_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("mid_ovf", {31'd0, err_ovf}, 32'd0);
        checkOutput("mid_idx", {28'd0, o_idx}, 32'd0);
        sendVector(11, 1'b1, 1'b1);
        checkOutput("mid_new_valid", {31'd0, o_valid}, 32'd1);
        drainAll(20, 1'b0);
        checkOutput("mid_count", delivered, 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
